// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared states and constants for the instruction loader
package instr_loader_pkg;

  // Bytes per instruction word on the upstream byte stream.
  localparam int BYTES_PER_WORD = 4;

  // The length header is a single little-endian word count.
  localparam int LEN_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// rtl/instr_loader_byte_assembler.sv - little-endian byte-to-word collector
module byte_assembler
  import instr_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear_i,
  input  logic                          byte_en_i,
  input  logic [7:0]                    byte_i,
  output logic [8*BYTES_PER_WORD-1:0]   word_o,
  output logic                          word_valid_o
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam int HOLD_W = 8 * (BYTES_PER_WORD - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [HOLD_W-1:0] held_q, held_d;

  // The final byte is not stored: it is presented directly so the word is
  // complete in the same cycle that byte is accepted.
  assign word_o       = {byte_i, held_q};
  assign word_valid_o = byte_en_i && (lane_q == LAST_LANE);

  // Lane advance and byte capture for the lower lanes.
  always_comb begin
    lane_d = lane_q;
    held_d = held_q;
    if (clear_i) begin
      lane_d = '0;
      held_d = '0;
    end else if (byte_en_i) begin
      if (lane_q == LAST_LANE) begin
        lane_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
        for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
          if (lane_q == LANE_W'(i)) held_d[i*8 +: 8] = byte_i;
        end
      end
    end
  end

  // Lane counter and partial-word register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q <= '0;
      held_q <= '0;
    end else begin
      lane_q <= lane_d;
      held_q <= held_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loads a length-prefixed byte image into instruction memory
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          SIZE      = 32768,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam int          WIDX_W   = $clog2(SIZE) + 1;
  localparam int          HDR_BITS = 8 * LEN_HDR_BYTES;
  localparam logic [31:0] SIZE_W   = 32'(SIZE);

  state_e              state_q, state_d;
  logic [HDR_BITS-1:0] len_q;
  logic [WIDX_W-1:0]   widx_q;
  logic [31:0]         mem_a_q, mem_wd_q;

  logic        asm_clear;
  logic        asm_en;
  logic        asm_valid;
  logic [31:0] asm_word;
  logic        last_word;

  // Ready is a pure function of state so it never loops back through valid.
  assign byte_ready = (state_q == LEN) || (state_q == DATA);
  assign asm_en     = byte_valid && byte_ready;
  assign asm_clear  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign last_word  = 32'(widx_q) == (32'(len_q) - 32'd1);
  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;

  byte_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (asm_clear),
    .byte_en_i    (asm_en),
    .byte_i       (byte_data),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  // Next-state selection and per-state status outputs.
  always_comb begin
    state_d  = state_q;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      IDLE: begin
        if (asm_clear) state_d = LEN;
      end
      LEN: begin
        busy = 1'b1;
        if (asm_valid) begin
          if (asm_word == 32'd0)      state_d = DONE;
          else if (asm_word > SIZE_W) state_d = ERR;
          else                        state_d = DATA;
        end
      end
      DATA: begin
        busy = 1'b1;
        if (asm_valid) state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        state_d = last_word ? DONE : DATA;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (asm_clear) state_d = LEN;
      end
      ERR: begin
        error = 1'b1;
        if (asm_clear) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, word count, word index and the held memory-port values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      widx_q   <= '0;
      mem_a_q  <= BASE_ADDR;
      mem_wd_q <= '0;
    end else begin
      state_q <= state_d;
      if (asm_clear) begin
        widx_q <= '0;
      end else if (state_q == WRITE) begin
        widx_q <= widx_q + 1'b1;
      end
      if ((state_q == LEN) && asm_valid) begin
        len_q <= asm_word[HDR_BITS-1:0];
      end
      // Address and data are staged on the word's last byte so they are
      // stable for the whole write cycle and then simply held.
      if ((state_q == DATA) && asm_valid) begin
        mem_wd_q <= asm_word;
        mem_a_q  <= (BASE_ADDR + (32'(widx_q) << 2)) & ~32'h3;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;

  localparam int          SIZE = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, busy, done, error, cpu_hold;
  logic [31:0] mem_a, mem_wd;

  int errors = 0;
  int checks = 0;
  int last_cycles = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] exp_a[$], exp_d[$];
  logic [31:0] log_a[$], log_d[$];

  always #5 clk = ~clk;

  instr_loader #(.SIZE(SIZE), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle: writes must match the model's queue, hold tracks done.
  always @(negedge clk) begin
    chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
    if (mem_we) begin
      log_a.push_back(mem_a);
      log_d.push_back(mem_wd);
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_a, mem_wd);
      end else begin
        chk("write_addr", mem_a, exp_a.pop_front());
        chk("write_data", mem_wd, exp_d.pop_front());
      end
    end
  end

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_q.push_back(w[i*8 +: 8]);
  endtask

  // Model: decode the image from the byte list and derive the write sequence.
  task automatic expect_image(output bit e_done, output bit e_err);
    logic [31:0] n;
    logic [31:0] w;
    n = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
    e_err  = (n > SIZE);
    e_done = !e_err;
    if (!e_err) begin
      for (int i = 0; i < int'(n); i++) begin
        w = {tx_q[4+4*i+3], tx_q[4+4*i+2], tx_q[4+4*i+1], tx_q[4+4*i]};
        exp_a.push_back(BASE + 32'(4 * i));
        exp_d.push_back(w);
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit rnd);
    int i = lo;
    int g = 0;
    while (i < hi && g < 2000) begin
      @(negedge clk);
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = tx_q[i];
      if (byte_valid && byte_ready) i++;
      g++;
    end
    last_cycles = g;
    if (i < hi) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got %0d bytes sent expected %0d", i - lo, hi - lo);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_end(input bit e_done, input bit e_err);
    int n = 0;
    while (!(done || error) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("end_done", 32'(done), 32'(e_done));
    chk("end_error", 32'(error), 32'(e_err));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_hold", 32'(cpu_hold), 32'(!e_done));
    chk("pending_writes", 32'(exp_a.size()), 32'd0);
  endtask

  task automatic run_image(input bit rnd);
    bit ed, ee;
    expect_image(ed, ee);
    do_start();
    send_range(0, tx_q.size(), rnd);
    wait_end(ed, ee);
  endtask

  initial begin
    bit ed, ee;
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_mem_a", mem_a, BASE);
    chk("rst_mem_wd", mem_wd, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word image with literal expectations.
    tx_q.delete(); add_word(32'd2); add_word(32'h13); add_word(32'h6F);
    log_a.delete(); log_d.delete();
    run_image(1'b0);
    chk("lit_nwrites", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk("lit_a0", log_a[0], 32'h0);
      chk("lit_d0", log_d[0], 32'h0000_0013);
      chk("lit_a1", log_a[1], 32'h4);
      chk("lit_d1", log_d[1], 32'h0000_006F);
    end
    chk("throughput", 32'(last_cycles <= 13), 32'd1);
    chk("lit_done", 32'(done), 32'd1);

    // Zero-length image.
    tx_q.delete(); add_word(32'd0);
    log_a.delete();
    run_image(1'b0);
    chk("zero_len_writes", 32'(log_a.size()), 32'd0);

    // Oversized header, then recovery.
    tx_q.delete(); add_word(32'h11);
    run_image(1'b0);
    chk("lit_err", 32'(error), 32'd1);
    tx_q.delete(); add_word(32'd1); add_word(32'hDEAD_BEEF);
    expect_image(ed, ee);
    do_start();
    chk("recover_busy", 32'(busy), 32'd1);
    chk("recover_error", 32'(error), 32'd0);
    send_range(0, tx_q.size(), 1'b0);
    wait_end(ed, ee);

    // Three words with random valid gaps.
    tx_q.delete(); add_word(32'd3);
    add_word(32'h0050_0093); add_word(32'h00A0_0113); add_word(32'h0020_81B3);
    log_a.delete();
    run_image(1'b1);
    chk("rand_nwrites", 32'(log_a.size()), 32'd3);

    // Full-size image at the SIZE boundary.
    tx_q.delete(); add_word(32'(SIZE));
    for (int i = 0; i < SIZE; i++) add_word(32'h1000_0000 + 32'(i * 3));
    run_image(1'b1);

    // Reset after the second data byte of the first word.
    tx_q.delete(); add_word(32'd2); tx_q.push_back(8'hAA); tx_q.push_back(8'hBB);
    do_start();
    send_range(0, 6, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hold", 32'(cpu_hold), 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tx_q.delete(); add_word(32'd2); add_word(32'h1111_2222); add_word(32'h3333_4444);
    run_image(1'b0);

    // Start pulsed in the middle of a word is ignored.
    tx_q.delete(); add_word(32'd3);
    add_word(32'hA5A5_0001); add_word(32'h5A5A_0002); add_word(32'hFFFF_0003);
    expect_image(ed, ee);
    do_start();
    send_range(0, 6, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_busy", 32'(busy), 32'd1);
    send_range(6, tx_q.size(), 1'b0);
    wait_end(ed, ee);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
